// File: rtl/axis_ram_pkg.sv
// Shared types for the AXI-Stream fronted RAM controller.
//   op_e     : command opcode carried in the top two bits of a command beat
//   status_e : response status carried in the top two bits of a response beat
//   state_e  : controller FSM states
package axis_ram_pkg;

    typedef enum logic [1:0] {
        OP_NOP            = 2'b00,
        OP_WRITE          = 2'b01,
        OP_READ           = 2'b10,
        OP_WRITE_READBACK = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_ADDR_ERR = 2'b01
    } status_e;

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_e;

    // Reads always answer; plain writes answer only when acknowledgements are enabled.
    function automatic logic rsp_due(op_e op, logic wr_ack);
        return (op == OP_READ) || (op == OP_WRITE_READBACK) || ((op == OP_WRITE) && wr_ack);
    endfunction

    function automatic logic is_write(op_e op);
        return (op == OP_WRITE) || (op == OP_WRITE_READBACK);
    endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM with registered read.
// A write cycle also loads the written word into the output register, so a
// write followed by a read of the same address sees the new value.
//   clk    : clock
//   i_en   : port enable; o_dout only changes on enabled cycles
//   i_we   : write enable (qualified by i_en)
//   i_addr : word address, must be < DEPTH when i_en is high
//   i_din  : write data
//   o_dout : registered read data, held while i_en is low
module sp_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 289,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_dout
);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_dout;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_din;
                r_dout        <= i_din;
            end else begin
                r_dout <= r_mem[i_addr];
            end
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/axis_ram_ctrl.sv
// Command/response controller wrapping a single-port RAM.
// Commands arrive on an AXI-Stream slave as {op, wdata, addr}; READ,
// WRITE_READBACK (and WRITE when WR_ACK=1) return {status, rdata} on an
// AXI-Stream master. After reset the RAM is swept to zero before any command
// is accepted.
//   aclk, areset            : clock, asynchronous active-high reset
//   s_axis_tdata/tvalid/tready : command stream
//   m_axis_tdata/tvalid/tready : response stream
//   busy                    : high whenever the controller is not idle
module axis_ram_ctrl
    import axis_ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 289,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter bit WR_ACK = 1'b0
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [2+DATA_W+ADDR_W-1:0] s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [2+DATA_W-1:0]      m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     busy
);

    localparam int CMD_W = 2 + DATA_W + ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e              r_state;
    logic [ADDR_W-1:0]   r_clr_ptr;
    op_e                 r_op;
    logic [ADDR_W-1:0]   r_addr;
    status_e             r_status;
    logic                r_tvalid;

    logic [ADDR_W-1:0]   w_cmd_addr;
    logic [DATA_W-1:0]   w_cmd_wdata;
    op_e                 w_cmd_op;
    logic                w_cmd_in_range;
    logic                w_accept;

    logic                w_ram_en;
    logic                w_ram_we;
    logic [ADDR_W-1:0]   w_ram_addr;
    logic [DATA_W-1:0]   w_ram_din;
    logic [DATA_W-1:0]   w_ram_dout;

    assign w_cmd_addr     = s_axis_tdata[ADDR_W-1:0];
    assign w_cmd_wdata    = s_axis_tdata[ADDR_W+DATA_W-1:ADDR_W];
    assign w_cmd_op       = op_e'(s_axis_tdata[CMD_W-1:CMD_W-2]);
    assign w_cmd_in_range = ({1'b0, w_cmd_addr} < DEPTH_L);
    assign w_accept       = s_axis_tvalid && s_axis_tready;

    assign s_axis_tready = (r_state == S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign m_axis_tvalid = r_tvalid;
    // The RAM output register is not enabled in RESP, so rdata stays stable
    // for as long as the beat is stalled. Errored commands never read the RAM,
    // hence the explicit zero.
    assign m_axis_tdata  = r_tvalid ? {r_status, (r_status == ST_OK) ? w_ram_dout : '0} : '0;

    // RAM port arbitration: clear sweep, write at command acceptance, read in EXEC.
    always_comb begin
        w_ram_en   = 1'b0;
        w_ram_we   = 1'b0;
        w_ram_addr = r_addr;
        w_ram_din  = w_cmd_wdata;
        case (r_state)
            S_CLEAR: begin
                w_ram_en   = 1'b1;
                w_ram_we   = 1'b1;
                w_ram_addr = r_clr_ptr;
                w_ram_din  = '0;
            end
            S_IDLE: begin
                if (w_accept && is_write(w_cmd_op) && w_cmd_in_range) begin
                    w_ram_en   = 1'b1;
                    w_ram_we   = 1'b1;
                    w_ram_addr = w_cmd_addr;
                end
            end
            S_EXEC: begin
                w_ram_en = (r_status == ST_OK);
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
            r_op      <= OP_NOP;
            r_addr    <= '0;
            r_status  <= ST_OK;
            r_tvalid  <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    if (r_clr_ptr == LAST_ADDR) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_clr_ptr <= r_clr_ptr + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (w_accept && (w_cmd_op != OP_NOP)) begin
                        r_op     <= w_cmd_op;
                        r_addr   <= w_cmd_addr;
                        r_status <= w_cmd_in_range ? ST_OK : ST_ADDR_ERR;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (rsp_due(r_op, WR_ACK)) begin
                        r_tvalid <= 1'b1;
                        r_state  <= S_RESP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RESP: begin
                    if (m_axis_tready) begin
                        r_tvalid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

    sp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk    (aclk),
        .i_en   (w_ram_en),
        .i_we   (w_ram_we),
        .i_addr (w_ram_addr),
        .i_din  (w_ram_din),
        .o_dout (w_ram_dout)
    );

endmodule

// File: tb/tb_axis_ram_ctrl.sv
// Bench for axis_ram_ctrl: two instances (WR_ACK=0 and WR_ACK=1) share clock
// and reset. Stimulus pushes expected response beats into per-instance queues;
// a negedge monitor pops and compares whenever a response beat is presented.
module tb_axis_ram_ctrl;
    import axis_ram_pkg::*;

    localparam int DEPTH = 289;
    localparam int CMD_W = 19;
    localparam int RSP_W = 10;

    logic clk = 1'b0;
    logic areset = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [CMD_W-1:0] s_tdata  [2];
    logic             s_tvalid [2];
    logic             s_tready [2];
    logic [RSP_W-1:0] m_tdata  [2];
    logic             m_tvalid [2];
    logic             m_tready [2];
    logic             busy     [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            axis_ram_ctrl #(
                .DATA_W (8),
                .DEPTH  (DEPTH),
                .ADDR_W (9),
                .WR_ACK (gi == 1)
            ) u_dut (
                .aclk          (clk),
                .areset        (areset),
                .s_axis_tdata  (s_tdata[gi]),
                .s_axis_tvalid (s_tvalid[gi]),
                .s_axis_tready (s_tready[gi]),
                .m_axis_tdata  (m_tdata[gi]),
                .m_axis_tvalid (m_tvalid[gi]),
                .m_axis_tready (m_tready[gi]),
                .busy          (busy[gi])
            );
        end
    endgenerate

    typedef struct {
        logic [9:0] data;
        int         rise;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [7:0] model [2][DEPTH];
    int         checks = 0;
    int         errors = 0;
    int         hs_cnt [2];
    bit         pend [2];
    logic [9:0] held [2];
    bit         rand_bp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qfront(input int k);
        if (k == 0) return q0[0];
        return q1[0];
    endfunction

    task automatic qpop(input int k);
        if (k == 0) q0.delete(0);
        else        q1.delete(0);
    endtask

    task automatic push_exp(input int k, input logic [9:0] d, input int rise);
        exp_t e;
        e.data = d;
        e.rise = rise;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Reference behaviour: memory array plus response rules. The beat becomes
    // visible on the second edge counting the accepting one.
    task automatic model_cmd(input int k, input op_e op, input logic [8:0] addr,
                             input logic [7:0] data, input int acc);
        bit inr;
        bit wack;
        inr  = (int'(addr) < DEPTH);
        wack = (k == 1);
        case (op)
            OP_WRITE: begin
                if (inr) model[k][addr] = data;
                if (wack) push_exp(k, inr ? {2'b00, data} : 10'h100, acc + 1);
            end
            OP_READ: begin
                if (inr) push_exp(k, {2'b00, model[k][addr]}, acc + 1);
                else     push_exp(k, 10'h100, acc + 1);
            end
            OP_WRITE_READBACK: begin
                if (inr) model[k][addr] = data;
                push_exp(k, inr ? {2'b00, data} : 10'h100, acc + 1);
            end
            default: ;
        endcase
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge
    // with tvalid still high so the caller can chain commands back to back.
    task automatic send(input int k, input op_e op, input logic [8:0] addr,
                        input logic [7:0] data, output int acc);
        acc = -1;
        s_tdata[k]  = {op, data, addr};
        s_tvalid[k] = 1'b1;
        for (int w = 0; w < 2000; w++) begin
            @(negedge clk);
            if (s_tready[k]) begin
                acc = cyc + 1;
                break;
            end
        end
        chk("cmd_accepted", 32'(acc >= 0), 1);
        if (acc >= 0) model_cmd(k, op, addr, data, acc);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int k);
        s_tvalid[k] = 1'b0;
    endtask

    task automatic cmd(input int k, input op_e op, input logic [8:0] addr, input logic [7:0] data);
        int acc;
        send(k, op, addr, data, acc);
        idle(k);
    endtask

    task automatic drain(input int k);
        for (int i = 0; i < 500; i++) begin
            if (qsize(k) == 0) break;
            @(negedge clk);
        end
        chk("drain_queue", 32'(qsize(k)), 0);
        @(posedge clk); #1;
    endtask

    // Called at posedge+1 right after reset release.
    task automatic sweep_check();
        int n0;
        int n1;
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy[0] && !busy[1]) break;
            if (busy[0] && !s_tready[0]) n0++;
            if (busy[1] && !s_tready[1]) n1++;
        end
        chk("sweep_cycles_0", 32'(n0), 289);
        chk("sweep_cycles_1", 32'(n1), 289);
        chk("idle_tready_0", 32'(s_tready[0]), 1);
        @(posedge clk); #1;
    endtask

    // Asserts reset, discards pending expectations, checks reset outputs.
    task automatic do_reset();
        areset = 1'b1;
        s_tvalid[0] = 1'b0;
        s_tvalid[1] = 1'b0;
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < DEPTH; a++) model[k][a] = 8'h00;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy",   32'(busy[k]), 1);
            chk("rst_tready", 32'(s_tready[k]), 0);
            chk("rst_tvalid", 32'(m_tvalid[k]), 0);
            chk("rst_tdata",  32'(m_tdata[k]), 0);
        end
        @(posedge clk); #1;
        areset = 1'b0;
    endtask

    // Response monitor.
    initial begin
        exp_t e;
        pend[0] = 1'b0; pend[1] = 1'b0;
        hs_cnt[0] = 0;  hs_cnt[1] = 0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (areset) begin
                    pend[k] = 1'b0;
                end else if (m_tvalid[k]) begin
                    chk("tready_low_in_resp", 32'(s_tready[k]), 0);
                    if (!pend[k]) begin
                        if (qsize(k) == 0) begin
                            chk("unexpected_beat", 32'(m_tdata[k]), 32'hFFFF_FFFF);
                        end else begin
                            e = qfront(k);
                            chk("rsp_data", 32'(m_tdata[k]), 32'(e.data));
                            chk("rsp_latency", 32'(cyc), 32'(e.rise));
                        end
                    end else begin
                        chk("rsp_hold", 32'(m_tdata[k]), 32'(held[k]));
                    end
                    held[k] = m_tdata[k];
                    if (m_tready[k]) begin
                        if (qsize(k) != 0) qpop(k);
                        hs_cnt[k]++;
                        pend[k] = 1'b0;
                    end else begin
                        pend[k] = 1'b1;
                    end
                end else if (pend[k]) begin
                    chk("tvalid_dropped", 0, 1);
                    pend[k] = 1'b0;
                end
            end
        end
    end

    // Random backpressure on the response streams when enabled.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_bp) begin
                m_tready[0] = 1'($urandom_range(0, 1));
                m_tready[1] = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        op_e        rop;
        logic [8:0] raddr;
        logic [7:0] rdat;
        int         acc;
        int         acc_prev;
        int         gap;
        int         hs_before;

        for (int k = 0; k < 2; k++) begin
            s_tdata[k]  = '0;
            s_tvalid[k] = 1'b0;
            m_tready[k] = 1'b1;
            for (int a = 0; a < DEPTH; a++) model[k][a] = 8'h00;
        end
        areset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy",   32'(busy[k]), 1);
            chk("rst_tready", 32'(s_tready[k]), 0);
            chk("rst_tvalid", 32'(m_tvalid[k]), 0);
            chk("rst_tdata",  32'(m_tdata[k]), 0);
        end
        areset = 1'b0;
        sweep_check();

        // Directed checks on the WR_ACK=0 instance.
        cmd(0, OP_READ, 9'd288, 8'h00);
        drain(0);
        cmd(0, OP_WRITE, 9'd5, 8'hA5);
        cmd(0, OP_READ, 9'd5, 8'h00);
        drain(0);

        m_tready[0] = 1'b0;
        hs_before = hs_cnt[0];
        cmd(0, OP_WRITE_READBACK, 9'd0, 8'h3C);
        repeat (12) @(posedge clk);
        #1;
        chk("stall_still_valid", 32'(m_tvalid[0]), 1);
        m_tready[0] = 1'b1;
        drain(0);
        chk("stall_one_handshake", 32'(hs_cnt[0] - hs_before), 1);

        cmd(0, OP_READ, 9'd300, 8'h00);
        cmd(0, OP_WRITE, 9'd300, 8'hFF);
        cmd(0, OP_READ, 9'd44, 8'h00);
        cmd(0, OP_NOP, 9'd5, 8'h11);
        cmd(0, OP_READ, 9'd5, 8'h00);
        drain(0);

        // Back-to-back acknowledged writes, tvalid held continuously.
        send(1, OP_WRITE, 9'd10, 8'h50, acc_prev);
        for (int i = 1; i < 6; i++) begin
            send(1, OP_WRITE, 9'(10 + i), 8'(8'h50 + i), acc);
            chk("b2b_spacing", 32'(acc - acc_prev), 3);
            acc_prev = acc;
        end
        idle(1);
        drain(1);
        cmd(1, OP_READ, 9'd13, 8'h00);
        drain(1);

        // Randomised traffic with random response backpressure.
        rand_bp = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 60; n++) begin
                rop   = op_e'(2'($urandom_range(0, 3)));
                raddr = ($urandom_range(0, 4) == 0) ? 9'($urandom_range(280, 511))
                                                    : 9'($urandom_range(0, 15));
                rdat  = 8'($urandom_range(0, 255));
                send(k, rop, raddr, rdat, acc);
                gap = $urandom_range(0, 2);
                if (gap > 0) begin
                    idle(k);
                    repeat (gap) @(posedge clk);
                    #1;
                end
            end
            idle(k);
            drain(k);
        end
        rand_bp = 1'b0;
        @(posedge clk); #1;
        m_tready[0] = 1'b1;
        m_tready[1] = 1'b1;

        // Reset in the middle of the clear sweep restarts it.
        do_reset();
        repeat (99) @(posedge clk);
        #1;
        do_reset();
        sweep_check();

        // Reset while a response is pending discards it and clears memory.
        cmd(0, OP_WRITE, 9'd5, 8'h77);
        m_tready[0] = 1'b0;
        cmd(0, OP_READ, 9'd5, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("pending_before_reset", 32'(m_tvalid[0]), 1);
        hs_before = hs_cnt[0];
        do_reset();
        m_tready[0] = 1'b1;
        sweep_check();
        chk("no_stale_beat", 32'(hs_cnt[0] - hs_before), 0);
        cmd(0, OP_READ, 9'd5, 8'h00);
        drain(0);

        chk("final_q0_empty", 32'(q0.size()), 0);
        chk("final_q1_empty", 32'(q1.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_ram_ctrl.md
AXIS_RAM_CTRL -- requirements
Module: axis_ram_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: width of one memory word.
REQ-002 Parameter DEPTH, default 289: number of memory words.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH) (9 for 289): width of the command address field.
REQ-004 Parameter WR_ACK, default 0: when 1, WRITE commands also produce a response beat.
REQ-005 Derived widths: CMD_W = 2+DATA_W+ADDR_W; RSP_W = 2+DATA_W.
REQ-006 Port aclk, input, 1: single clock; all logic is on the rising edge.
REQ-007 Port areset, input, 1: reset; one clock; reset is asynchronous and active-high.
REQ-008 Port s_axis_tdata, input, CMD_W: command; [ADDR_W-1:0]=addr, [ADDR_W+DATA_W-1:ADDR_W]=wdata, [CMD_W-1:CMD_W-2]=op.
REQ-009 Ports s_axis_tvalid (input, 1) and s_axis_tready (output, 1): command handshake.
REQ-010 Port m_axis_tdata, output, RSP_W: response {status[1:0], rdata[DATA_W-1:0]}.
REQ-011 Ports m_axis_tvalid (output, 1) and m_axis_tready (input, 1): response handshake.
REQ-012 Port busy, output, 1: high in every state other than IDLE.

Function
REQ-013 Opcodes: 00 NOP, 01 WRITE, 10 READ, 11 WRITE_READBACK.
REQ-014 Status codes: 00 OK, 01 ADDR_ERR (addr >= DEPTH), 10 reserved, 11 reserved.
REQ-015 States: CLEAR, IDLE, EXEC, RESP.
REQ-016 CLEAR: writes zero to address clr_ptr each cycle, 0..DEPTH-1; s_axis_tready=0; moves to IDLE after address DEPTH-1 (DEPTH cycles total).
REQ-017 IDLE: s_axis_tready=1.
REQ-018 IDLE, command accepted (tvalid&&tready) with op=NOP: command dropped, no response, stay in IDLE.
REQ-019 IDLE, other accepted command: latch op/addr/wdata.
REQ-020 For WRITE and WRITE_READBACK with an in-range address, the memory write occurs at the acceptance edge.
REQ-021 After any non-NOP acceptance, go to EXEC.
REQ-022 EXEC (one cycle): registered read of mem[addr]; go to RESP if a response is due, else IDLE.
REQ-023 A response is due for READ and WRITE_READBACK always, and for WRITE only when WR_ACK=1.
REQ-024 WRITE_READBACK returns the newly written value (write-before-read).
REQ-025 RESP: m_axis_tvalid=1; m_axis_tdata is held stable until m_axis_tready=1; on that handshake tvalid falls and state goes to IDLE.
REQ-026 Response latency: tvalid rises 2 cycles after command acceptance; peak throughput is one responding command per 3 cycles.
REQ-027 Out-of-range address: no memory write; response carries status=01 and rdata=0; a WRITE with WR_ACK=0 is dropped silently.
REQ-028 WRITE response (WR_ACK=1): status=00, rdata = written value.
REQ-029 s_axis_tready is 0 in CLEAR, EXEC and RESP; commands presented then are stalled, never lost.
REQ-030 m_axis_tvalid never depends combinationally on m_axis_tready.

Reset
REQ-031 On areset high (asynchronous): state=CLEAR, clr_ptr=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, busy=1.
REQ-032 Reset asserted mid-CLEAR restarts the sweep from address 0.
REQ-033 Reset asserted during EXEC or RESP discards the pending response.
REQ-034 Memory contents are not reset directly; they are zeroed only by the CLEAR sweep.

Structure
REQ-035 A package axis_ram_pkg holds the op_e enum (NOP, WRITE, READ, WRITE_READBACK), the status_e enum (OK, ADDR_ERR) and the state_e enum.
REQ-036 Sub-module sp_ram: single-port synchronous RAM, parametrised DATA_W/DEPTH, with registered read and write-before-read; the controller owns the FSM and the handshakes.

Verification
REQ-037 Reset release -> busy=1 and tready=0 for exactly 289 cycles; then READ addr 288 -> response 0x000.
REQ-038 WRITE addr 5 data 0xA5 (WR_ACK=0), then READ addr 5 -> one response only, tdata={00,0xA5}, tvalid rising 2 cycles after the READ is accepted.
REQ-039 WRITE_READBACK addr 0 data 0x3C with m_axis_tready held low 10 cycles -> tdata {00,0x3C} stable all 10 cycles and tready=0 throughout; one handshake when released.
REQ-040 READ addr 300 -> response {01,0x00}; a following WRITE addr 300 data 0xFF -> no memory change; READ addr 44 -> 0x00.
REQ-041 areset pulsed at CLEAR cycle 100 and again during RESP -> sweep restarts at 0 (289 more cycles); no stale response beat appears.
REQ-042 WR_ACK=1, back-to-back WRITE commands held valid continuously -> each accepted every 3 cycles, each acknowledged {00,data}, none dropped.
